// File: rtl/sample_packer.sv
// Packs a stream of DATA_WIDTH samples into BUS_WIDTH-lane vectors, lane 0 = oldest.
// A vector closes when it is full or on s_last; one output register plus a frozen fill buffer give two-deep buffering.
module sample_packer #(
  parameter int unsigned BUS_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data [0:BUS_WIDTH-1],
  output logic [$clog2(BUS_WIDTH):0] o_count
);

  localparam int unsigned IDX_W = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUS_WIDTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUS_WIDTH - 1);

  if ((BUS_WIDTH < 1) || ((BUS_WIDTH & (BUS_WIDTH - 1)) != 0)) begin : g_bad_bus_width
    $fatal(1, "sample_packer: BUS_WIDTH must be a power of 2");
  end

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] fill [0:BUS_WIDTH-1];

  logic                  accept_c;
  logic                  complete_c;
  logic                  slot_free_c;
  logic                  load_c;
  logic [DATA_WIDTH-1:0] vec_c [0:BUS_WIDTH-1];
  logic [CNT_W-1:0]      count_c;

  // s_ready depends on rst directly so no sample is taken while reset is applied
  assign s_ready     = (state == FILL) && !rst;
  assign accept_c    = s_valid && s_ready;
  assign complete_c  = accept_c && ((idx == LAST_IDX) || s_last);
  assign slot_free_c = !o_valid || o_ready;
  assign load_c      = slot_free_c && (((state == FILL) && complete_c) || (state == HOLD));
  assign count_c     = CNT_W'(idx) + CNT_W'(1);

  // Vector to transfer: in FILL the closing sample bypasses the buffer into lane idx;
  // lanes above idx are already zero because the buffer is cleared after every transfer.
  always_comb begin
    for (int i = 0; i < int'(BUS_WIDTH); i++) begin
      vec_c[i] = fill[i];
      if ((state == FILL) && (IDX_W'(i) == idx)) begin
        vec_c[i] = s_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL;
      idx     <= '0;
      o_valid <= 1'b0;
      o_count <= '0;
      for (int i = 0; i < int'(BUS_WIDTH); i++) begin
        fill[i]   <= '0;
        o_data[i] <= '0;
      end
    end else begin
      // Output register: a new load wins over the drop after an accept
      if (load_c) begin
        o_valid <= 1'b1;
        o_count <= count_c;
        for (int i = 0; i < int'(BUS_WIDTH); i++) begin
          o_data[i] <= vec_c[i];
        end
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end

      case (state)
        FILL: begin
          if (accept_c) begin
            if (complete_c && slot_free_c) begin
              idx <= '0;
              for (int i = 0; i < int'(BUS_WIDTH); i++) begin
                fill[i] <= '0;
              end
            end else if (complete_c) begin
              fill[idx] <= s_data;
              state     <= HOLD;
            end else begin
              fill[idx] <= s_data;
              idx       <= idx + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (slot_free_c) begin
            idx   <= '0;
            state <= FILL;
            for (int i = 0; i < int'(BUS_WIDTH); i++) begin
              fill[i] <= '0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_packer.sv
// Directed bench for sample_packer: a queue-based model of completed vectors is checked
// against the DUT every cycle, plus literal checks of the delivered vector sequence.
module tb_sample_packer;

  localparam int unsigned BW = 4;
  localparam int unsigned DW = 6;
  localparam int unsigned CW = $clog2(BW) + 1;

  typedef struct {
    logic [DW-1:0] lane [BW];
    int            cnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic [DW-1:0] o_data [0:BW-1];
  logic [CW-1:0] o_count;

  sample_packer #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_count (o_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: completed vectors not yet handed downstream (head = what o_data must show)
  vec_t          q[$];
  logic [DW-1:0] part[$];
  logic [BW*DW-1:0] got_data[$];
  int            got_cnt[$];
  bit            rst_seen = 1'b0;
  bit            started  = 1'b0;
  bit            m_ready, m_valid;
  vec_t          nv;
  logic [BW*DW-1:0] pk;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      part.delete();
      rst_seen = 1'b1;
      started  = 1'b1;
    end else begin
      rst_seen = 1'b0;
      m_ready  = (q.size() < 2);
      m_valid  = (q.size() > 0);
      if (o_valid && o_ready) begin
        for (int i = 0; i < int'(BW); i++) pk[(BW-1-i)*DW +: DW] = o_data[i];
        got_data.push_back(pk);
        got_cnt.push_back(int'(o_count));
      end
      if (m_valid && o_ready) void'(q.pop_front());
      if (s_valid && m_ready) begin
        part.push_back(s_data);
        if (part.size() == BW || s_last) begin
          for (int i = 0; i < int'(BW); i++) nv.lane[i] = (i < part.size()) ? part[i] : '0;
          nv.cnt = part.size();
          q.push_back(nv);
          part.delete();
        end
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (started) begin
      chk("s_ready", 32'(s_ready), 32'(!rst && (q.size() < 2)));
      if (rst_seen) begin
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_count", 32'(o_count), 32'd0);
        for (int i = 0; i < int'(BW); i++) chk("rst_o_data", 32'(o_data[i]), 32'd0);
      end else begin
        chk("o_valid", 32'(o_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
          chk("o_count", 32'(o_count), 32'(q[0].cnt));
          for (int i = 0; i < int'(BW); i++) chk("o_data", 32'(o_data[i]), 32'(q[0].lane[i]));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    int b;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    b = 0;
    @(negedge clk);
    while (!s_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (!s_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: s_ready stuck 0 for sample %0d", d);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic expect_vec(input string name, input logic [BW*DW-1:0] d, input int c);
    n_checks++;
    if (got_data.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no vector delivered, expected %0h count %0d", name, d, c);
    end else begin
      logic [BW*DW-1:0] gd;
      int gc;
      gd = got_data.pop_front();
      gc = got_cnt.pop_front();
      if (gd !== d || gc != c) begin
        n_fail++;
        $display("FAIL %s: got %0h count %0d expected %0h count %0d", name, gd, gc, d, c);
      end
    end
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(s_ready), 32'd1);
    @(posedge clk); #1;

    // Back-to-back full vectors
    o_ready = 1'b1;
    for (int v = 1; v <= 8; v++) send(DW'(v), 1'b0);
    step(3);
    expect_vec("b2b_v0", {6'd1, 6'd2, 6'd3, 6'd4}, 4);
    expect_vec("b2b_v1", {6'd5, 6'd6, 6'd7, 6'd8}, 4);

    // Short vectors closed by s_last, full-scale data
    send(6'd9, 1'b0);
    send(6'd10, 1'b1);
    send(6'd63, 1'b1);
    step(3);
    expect_vec("last_2", {6'd9, 6'd10, 6'd0, 6'd0}, 2);
    expect_vec("last_1", {6'd63, 6'd0, 6'd0, 6'd0}, 1);

    // Backpressure: one vector in output, one held in fill buffer
    o_ready = 1'b0;
    for (int v = 1; v <= 8; v++) send(DW'(v), 1'b0);
    @(negedge clk);
    chk("hold_s_ready", 32'(s_ready), 32'd0);
    chk("hold_o_valid", 32'(o_valid), 32'd1);
    chk("hold_lane0", 32'(o_data[0]), 32'd1);
    @(posedge clk); #1;
    o_ready = 1'b1;
    @(posedge clk); #1;
    o_ready = 1'b0;
    @(negedge clk);
    chk("pulse_o_valid", 32'(o_valid), 32'd1);
    chk("pulse_lane0", 32'(o_data[0]), 32'd5);
    chk("pulse_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    o_ready = 1'b1;
    step(3);
    expect_vec("bp_v0", {6'd1, 6'd2, 6'd3, 6'd4}, 4);
    expect_vec("bp_v1", {6'd5, 6'd6, 6'd7, 6'd8}, 4);

    // Reset discards a partial vector, even with a concurrent handshake
    send(6'd11, 1'b0);
    send(6'd12, 1'b0);
    send(6'd13, 1'b0);
    s_valid = 1'b1;
    s_data  = 6'd14;
    rst     = 1'b1;
    step(2);
    s_valid = 1'b0;
    rst     = 1'b0;
    for (int v = 20; v <= 23; v++) send(DW'(v), 1'b0);
    step(3);
    expect_vec("post_rst", {6'd20, 6'd21, 6'd22, 6'd23}, 4);

    // s_last without s_valid is ignored
    send(6'd30, 1'b0);
    s_last = 1'b1;
    step(1);
    s_last = 1'b0;
    send(6'd31, 1'b0);
    send(6'd32, 1'b0);
    s_last = 1'b1;
    step(1);
    s_last = 1'b0;
    send(6'd33, 1'b0);
    step(3);
    expect_vec("stray_last", {6'd30, 6'd31, 6'd32, 6'd33}, 4);
    chk("no_extra_vectors", 32'(got_data.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_packer.md
SAMPLE_PACKER -- requirements
Module: sample_packer

Interface
REQ-001 Parameter BUS_WIDTH, default 4, number of lanes per output vector; SHALL be a power of 2, otherwise elaboration SHALL stop with $fatal.
REQ-002 Parameter DATA_WIDTH, default 6, bits per sample.
REQ-003 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_valid  input  1  input sample valid.
REQ-006 s_ready  output  1  input sample accepted when s_valid && s_ready at posedge.
REQ-007 s_data  input  DATA_WIDTH  input sample.
REQ-008 s_last  input  1  qualified by s_valid; closes the current vector after this sample.
REQ-009 o_valid  output  1  output vector valid; drives the i_valid of a downstream mean block.
REQ-010 o_ready  input  1  downstream accept; tie high when the sink has no backpressure.
REQ-011 o_data  output  unpacked array [0:BUS_WIDTH-1] of DATA_WIDTH  packed vector, lane 0 = oldest sample.
REQ-012 o_count  output  $clog2(BUS_WIDTH)+1  number of real samples in o_data (1..BUS_WIDTH).

Function
REQ-013 Block SHALL contain one fill buffer (BUS_WIDTH lanes, lane index idx) and one output register (o_data, o_count, o_valid).
REQ-014 FSM states SHALL be FILL and HOLD; s_ready SHALL be 1 in FILL and 0 in HOLD (and 0 while rst is high).
REQ-015 In FILL, an accepted sample SHALL be written to fill lane idx and idx SHALL increment.
REQ-016 A vector SHALL complete when the accepted sample lands in lane BUS_WIDTH-1 or carries s_last=1.
REQ-017 On completion, lanes above the last written lane SHALL be zero in the transferred vector; count = idx+1.
REQ-018 Output slot is free at an edge when o_valid==0 or o_ready==1.
REQ-019 If the slot is free at the completing edge, the vector SHALL load into the output register at that edge (o_valid high the next cycle; latency 1 cycle from completing handshake), idx SHALL return to 0, state stays FILL.
REQ-020 If the slot is not free, state SHALL go to HOLD with the fill buffer frozen; at the first edge where the slot is free it SHALL transfer, clear idx and return to FILL.
REQ-021 o_valid SHALL stay high with o_data/o_count stable until an edge with o_ready=1; then it SHALL drop unless a new vector loads at the same edge, in which case o_valid stays 1 with new data.
REQ-022 Vectors SHALL be emitted in order; no sample SHALL be dropped or duplicated.
REQ-023 s_last with s_valid=0, or with s_ready=0, SHALL be ignored.
REQ-024 Full-scale samples (2**DATA_WIDTH-1) SHALL pass unmodified; no arithmetic on data.
REQ-025 Back-to-back operation with o_ready=1 SHALL sustain one sample per cycle with s_ready never deasserting.

Reset
REQ-026 With rst high at a posedge: state=FILL, idx=0, o_valid=0, o_data all lanes 0, o_count=0, fill buffer cleared.
REQ-027 rst SHALL take priority over any concurrent handshake; a partially filled or held vector SHALL be discarded.
REQ-028 s_ready SHALL be 1 in the first cycle after rst deasserts.

Verification (BUS_WIDTH=4, DATA_WIDTH=6)
REQ-029 o_ready=1, samples 1..8 back-to-back -> o_valid one cycle after 4th and 8th sample, o_data {1,2,3,4} then {5,6,7,8}, o_count=4, s_ready constantly 1.
REQ-030 samples 9,10 with s_last on 10 -> o_data {9,10,0,0}, o_count=2; single sample 63 with s_last -> {63,0,0,0}, o_count=1.
REQ-031 o_ready=0, feed 8 samples -> first vector held in output, second in fill buffer, s_ready=0 after 8th; raise o_ready -> {1,2,3,4} then {5,6,7,8} on consecutive accepts, s_ready returns to 1.
REQ-032 o_valid=1 and HOLD, o_ready pulsed for one cycle -> same edge loads next vector, o_valid stays 1, data changes, FILL resumes.
REQ-033 rst after 3 accepted samples, then samples 20..23 -> single vector {20,21,22,23}, o_count=4; all outputs 0 during reset.
REQ-034 s_last asserted with s_valid=0 between samples -> no early close; vector completes at 4 samples.
